// File: rtl/rf_write_arbiter.sv
// Purpose : arbitrates the single register-file write port between pipeline
//           writeback (WB) and a small FIFO of long-latency (mul/div) results,
//           and keeps a per-register busy scoreboard for decode hazard stalls.
// Latency : the grant is decided combinationally in cycle N. Write_Reg/W_Addr/W_Data
//           are registered and visible after posedge N.
// Backpr. : WB normally wins. A queue head denied AGE_MAX times forces one FORCE
//           cycle in which wb_stall=1. mdu_ready drops when the FIFO is full.
//
// Ports:
//   Clk, Clr                       clock, async active-high reset
//   wb_valid/wb_addr/wb_data       writeback request, wb_stall = refused
//   mdu_valid/mdu_addr/mdu_data    MDU result, mdu_ready = FIFO can accept
//   issue_valid/issue_addr         long-latency issue, marks destination busy
//   rd_addr_a/b -> stall_a/b       decode read-port hazard flags
//   Write_Reg/W_Addr/W_Data        registered register-file write port

module rf_write_arbiter #(
  parameter int ADDR    = 5,
  parameter int SIZE    = 32,
  parameter int DEPTH   = 2,
  parameter int AGE_MAX = 3
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic            wb_valid,
  input  logic [ADDR-1:0] wb_addr,
  input  logic [SIZE-1:0] wb_data,
  output logic            wb_stall,
  input  logic            mdu_valid,
  input  logic [ADDR-1:0] mdu_addr,
  input  logic [SIZE-1:0] mdu_data,
  output logic            mdu_ready,
  input  logic            issue_valid,
  input  logic [ADDR-1:0] issue_addr,
  input  logic [ADDR-1:0] rd_addr_a,
  input  logic [ADDR-1:0] rd_addr_b,
  output logic            stall_a,
  output logic            stall_b,
  output logic            Write_Reg,
  output logic [ADDR-1:0] W_Addr,
  output logic [SIZE-1:0] W_Data
);

  localparam int NREG  = 1 << ADDR;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AGE_W = (AGE_MAX > 1) ? $clog2(AGE_MAX) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [AGE_W-1:0] AGE_LIM  = AGE_W'(AGE_MAX - 1);

  typedef enum logic {NORMAL = 1'b0, FORCE = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [AGE_W-1:0]  age_q, age_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR-1:0]   q_addr_q [DEPTH];
  logic [SIZE-1:0]   q_data_q [DEPTH];
  logic [NREG-1:0]   busy_q, busy_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR-1:0]   w_addr_q, w_addr_d;
  logic [SIZE-1:0]   w_data_q, w_data_d;

  logic              wb_req;
  logic              q_ne;
  logic              push;
  logic              grant_wb;
  logic              grant_q;
  logic [ADDR-1:0]   head_addr;
  logic [SIZE-1:0]   head_data;

  // Address-0 requests never touch the port or the queue.
  assign wb_req    = wb_valid && (wb_addr != '0);
  assign q_ne      = (count_q != '0);
  assign mdu_ready = (count_q < DEPTH_C);
  assign push      = mdu_valid && mdu_ready && (mdu_addr != '0);
  assign head_addr = q_addr_q[rd_ptr_q];
  assign head_data = q_data_q[rd_ptr_q];

  assign wb_stall  = (state_q == FORCE);
  assign stall_a   = busy_q[rd_addr_a];
  assign stall_b   = busy_q[rd_addr_b];
  assign Write_Reg = wr_en_q;
  assign W_Addr    = w_addr_q;
  assign W_Data    = w_data_q;

  // Arbitration FSM and head-age tracking.
  always_comb begin
    state_d  = state_q;
    age_d    = age_q;
    grant_wb = 1'b0;
    grant_q  = 1'b0;
    case (state_q)
      NORMAL: begin
        if (wb_req) begin
          grant_wb = 1'b1;
        end else if (q_ne) begin
          grant_q = 1'b1;
        end
        if (!q_ne || grant_q) begin
          age_d = '0;
        end else if (age_q == AGE_LIM) begin
          // Head denied AGE_MAX times in a row: steal the next cycle.
          state_d = FORCE;
          age_d   = '0;
        end else begin
          age_d = age_q + 1'b1;
        end
      end
      FORCE: begin
        // Head cannot leave the queue except through a grant, so it is still
        // present here. The q_ne guard only protects against a corrupt count.
        grant_q = q_ne;
        age_d   = '0;
        state_d = NORMAL;
      end
      default: begin
        state_d = NORMAL;
        age_d   = '0;
      end
    endcase
  end

  // FIFO pointers and occupancy. Simultaneous push/pop keeps count unchanged.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (grant_q) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    case ({push, grant_q})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Scoreboard: a queue write clears the busy bit, a new issue sets it. The
  // set is applied last so that it wins on the same register. WB grants
  // leave the bit alone.
  always_comb begin
    busy_d = busy_q;
    if (grant_q) begin
      busy_d[head_addr] = 1'b0;
    end
    if (issue_valid && (issue_addr != '0)) begin
      busy_d[issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Write-port next values.
  always_comb begin
    wr_en_d  = grant_wb || grant_q;
    w_addr_d = '0;
    w_data_d = '0;
    if (grant_wb) begin
      w_addr_d = wb_addr;
      w_data_d = wb_data;
    end else if (grant_q) begin
      w_addr_d = head_addr;
      w_data_d = head_data;
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q  <= NORMAL;
      age_q    <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      busy_q   <= '0;
      wr_en_q  <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr_q[i] <= '0;
        q_data_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      age_q    <= age_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      busy_q   <= busy_d;
      wr_en_q  <= wr_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      if (push) begin
        q_addr_q[wr_ptr_q] <= mdu_addr;
        q_data_q[wr_ptr_q] <= mdu_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Purpose : directed self-checking bench for rf_write_arbiter.
// Latency : outputs are checked 1 ns after each rising edge.
// Backpr. : the bench models upstream WB hold-on-stall by keeping its inputs.
module tb_rf_write_arbiter;

  logic        Clk = 1'b0;
  logic        Clr;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        stall_a;
  logic        stall_b;
  logic        Write_Reg;
  logic [4:0]  W_Addr;
  logic [31:0] W_Data;

  int n_checks = 0;
  int n_fail   = 0;

  rf_write_arbiter #(.ADDR(5), .SIZE(32), .DEPTH(2), .AGE_MAX(3)) dut (
    .Clk(Clk), .Clr(Clr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .stall_a(stall_a), .stall_b(stall_b),
    .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0;
    issue_valid = 1'b0; issue_addr = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    Clr = 1'b1;
    #3;
    n_checks++;
    if (Write_Reg !== 1'b0 || W_Addr !== 5'd0 || W_Data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_port: got we=%b a=%0d d=%h want 0/0/0", Write_Reg, W_Addr, W_Data);
    end
    n_checks++;
    if (mdu_ready !== 1'b1 || wb_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flow: got mdu_ready=%b wb_stall=%b want 1/0", mdu_ready, wb_stall);
    end
    tick(); tick();
    Clr = 1'b0;
    tick();
    n_checks++;
    if (Write_Reg !== 1'b0 || stall_a !== 1'b0 || stall_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got we=%b sa=%b sb=%b want 0/0/0", Write_Reg, stall_a, stall_b);
    end
  endtask

  task automatic test_wb_only();
    rd_addr_a = 5'd5; rd_addr_b = 5'd2;
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_AAAA;
    tick();
    n_checks++;
    if (Write_Reg !== 1'b1 || W_Addr !== 5'd5 || W_Data !== 32'h0000_AAAA) begin
      n_fail++;
      $display("FAIL wb_only: got we=%b a=%0d d=%h want 1/5/0000aaaa", Write_Reg, W_Addr, W_Data);
    end
    n_checks++;
    if (stall_a !== 1'b0 || stall_b !== 1'b0 || wb_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_only_stalls: got sa=%b sb=%b ws=%b want 0/0/0", stall_a, stall_b, wb_stall);
    end
    idle_inputs();
    tick();
    n_checks++;
    if (Write_Reg !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_only_idle: got we=%b want 0", Write_Reg);
    end
  endtask

  task automatic test_collision();
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'h1234;
    tick();
    n_checks++;
    if (Write_Reg !== 1'b1 || W_Addr !== 5'd3 || W_Data !== 32'h33) begin
      n_fail++;
      $display("FAIL collision_c1: got we=%b a=%0d d=%h want 1/3/33", Write_Reg, W_Addr, W_Data);
    end
    idle_inputs();
    tick();
    n_checks++;
    if (Write_Reg !== 1'b1 || W_Addr !== 5'd7 || W_Data !== 32'h1234) begin
      n_fail++;
      $display("FAIL collision_c2: got we=%b a=%0d d=%h want 1/7/1234", Write_Reg, W_Addr, W_Data);
    end
    tick();
    n_checks++;
    if (Write_Reg !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_c3: got we=%b want 0", Write_Reg);
    end
  endtask

  task automatic test_addr_zero();
    // WB to r0 alone: no write.
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
    tick();
    n_checks++;
    if (Write_Reg !== 1'b0) begin
      n_fail++;
      $display("FAIL addr0_wb: got we=%b want 0", Write_Reg);
    end
    // MDU to r0 is dropped. MDU to r6 must still drain past a WB to r0.
    mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'hBAD0;
    tick();
    mdu_addr = 5'd6; mdu_data = 32'h66;
    tick();
    n_checks++;
    if (Write_Reg !== 1'b0) begin
      n_fail++;
      $display("FAIL addr0_mdu: got we=%b want 0", Write_Reg);
    end
    mdu_valid = 1'b0;
    tick();
    n_checks++;
    if (Write_Reg !== 1'b1 || W_Addr !== 5'd6 || W_Data !== 32'h66) begin
      n_fail++;
      $display("FAIL addr0_nonblock: got we=%b a=%0d d=%h want 1/6/66", Write_Reg, W_Addr, W_Data);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_starvation();
    logic [4:0]  exp_a [6];
    logic [31:0] exp_d [6];
    logic        exp_s [6];
    logic [31:0] wdat  [6];
    exp_a = '{5'd10, 5'd10, 5'd10, 5'd10, 5'd8, 5'd10};
    exp_d = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h88, 32'h103};
    exp_s = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    // Data 0x103 is held through the stall cycle, as the upstream would.
    wdat  = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h103, 32'h103};
    wb_valid = 1'b1; wb_addr = 5'd10;
    mdu_valid = 1'b1; mdu_addr = 5'd8; mdu_data = 32'h88;
    for (int i = 0; i < 6; i++) begin
      wb_data = wdat[i];
      tick();
      mdu_valid = 1'b0;
      n_checks++;
      if (Write_Reg !== 1'b1 || W_Addr !== exp_a[i] || W_Data !== exp_d[i] || wb_stall !== exp_s[i]) begin
        n_fail++;
        $display("FAIL starve_%0d: got we=%b a=%0d d=%h ws=%b want 1/%0d/%h/%b",
                 i, Write_Reg, W_Addr, W_Data, wb_stall, exp_a[i], exp_d[i], exp_s[i]);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_full_queue();
    wb_valid = 1'b1; wb_addr = 5'd11; wb_data = 32'hB0;
    mdu_valid = 1'b1; mdu_addr = 5'd12; mdu_data = 32'hC0;
    tick();
    n_checks++;
    if (mdu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_one: got mdu_ready=%b want 1", mdu_ready);
    end
    mdu_addr = 5'd13; mdu_data = 32'hD0;
    tick();
    n_checks++;
    if (mdu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_two: got mdu_ready=%b want 0", mdu_ready);
    end
    // Offered while full: must be dropped.
    mdu_addr = 5'd14; mdu_data = 32'hE0;
    tick();
    mdu_valid = 1'b0;
    tick();
    n_checks++;
    if (wb_stall !== 1'b1 || mdu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_force: got ws=%b mdu_ready=%b want 1/0", wb_stall, mdu_ready);
    end
    tick();
    n_checks++;
    if (W_Addr !== 5'd12 || W_Data !== 32'hC0 || mdu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop: got a=%0d d=%h mdu_ready=%b want 12/c0/1", W_Addr, W_Data, mdu_ready);
    end
    wb_valid = 1'b0;
    tick();
    n_checks++;
    if (Write_Reg !== 1'b1 || W_Addr !== 5'd13 || W_Data !== 32'hD0) begin
      n_fail++;
      $display("FAIL full_second: got we=%b a=%0d d=%h want 1/13/d0", Write_Reg, W_Addr, W_Data);
    end
    tick();
    n_checks++;
    if (Write_Reg !== 1'b0) begin
      n_fail++;
      $display("FAIL full_dropped: got we=%b a=%0d want 0", Write_Reg, W_Addr);
    end
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    rd_addr_a = 5'd9; rd_addr_b = 5'd0;
    issue_valid = 1'b1; issue_addr = 5'd9;
    tick();
    issue_addr = 5'd0;
    n_checks++;
    if (stall_a !== 1'b1 || stall_b !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_issue: got sa=%b sb=%b want 1/0", stall_a, stall_b);
    end
    // Issue to r0 while a WB writes the busy r9: nothing changes.
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h909;
    tick();
    issue_valid = 1'b0;
    n_checks++;
    if (stall_a !== 1'b1 || stall_b !== 1'b0 || W_Addr !== 5'd9) begin
      n_fail++;
      $display("FAIL sb_wb_busy: got sa=%b sb=%b a=%0d want 1/0/9", stall_a, stall_b, W_Addr);
    end
    wb_valid = 1'b0;
    mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'h99;
    tick();
    mdu_valid = 1'b0;
    n_checks++;
    if (stall_a !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_queued: got sa=%b want 1", stall_a);
    end
    tick();
    n_checks++;
    if (Write_Reg !== 1'b1 || W_Addr !== 5'd9 || W_Data !== 32'h99 || stall_a !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_clear: got we=%b a=%0d d=%h sa=%b want 1/9/99/0", Write_Reg, W_Addr, W_Data, stall_a);
    end
    // Set wins over clear: reissue r5 in the cycle its queued result is written.
    rd_addr_a = 5'd5;
    issue_valid = 1'b1; issue_addr = 5'd5;
    tick();
    issue_valid = 1'b0;
    mdu_valid = 1'b1; mdu_addr = 5'd5; mdu_data = 32'h55;
    tick();
    mdu_valid = 1'b0;
    issue_valid = 1'b1; issue_addr = 5'd5;
    tick();
    issue_valid = 1'b0;
    n_checks++;
    if (W_Addr !== 5'd5 || stall_a !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_set_wins: got a=%0d sa=%b want 5/1", W_Addr, stall_a);
    end
    mdu_valid = 1'b1; mdu_data = 32'h56;
    tick();
    mdu_valid = 1'b0;
    tick();
    n_checks++;
    if (W_Data !== 32'h56 || stall_a !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_final_clear: got d=%h sa=%b want 56/0", W_Data, stall_a);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    rd_addr_a = 5'd4; rd_addr_b = 5'd0;
    wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h11;
    mdu_valid = 1'b1; mdu_addr = 5'd20; mdu_data = 32'h20;
    issue_valid = 1'b1; issue_addr = 5'd4;
    tick();
    issue_valid = 1'b0;
    mdu_addr = 5'd21; mdu_data = 32'h21;
    tick();
    idle_inputs();
    n_checks++;
    if (mdu_ready !== 1'b0 || stall_a !== 1'b1 || Write_Reg !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pre: got mdu_ready=%b sa=%b we=%b want 0/1/1", mdu_ready, stall_a, Write_Reg);
    end
    #1 Clr = 1'b1;
    #1;
    n_checks++;
    if (Write_Reg !== 1'b0 || W_Addr !== 5'd0 || W_Data !== 32'd0 || mdu_ready !== 1'b1 ||
        stall_a !== 1'b0 || wb_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async: got we=%b a=%0d d=%h rdy=%b sa=%b ws=%b want 0/0/0/1/0/0",
               Write_Reg, W_Addr, W_Data, mdu_ready, stall_a, wb_stall);
    end
    tick(); tick();
    Clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (Write_Reg !== 1'b0 || stall_a !== 1'b0) begin
        n_fail++;
        $display("FAIL rmid_post_%0d: got we=%b a=%0d sa=%b want 0/-/0", i, Write_Reg, W_Addr, stall_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wb_only();
    test_collision();
    test_addr_zero();
    test_starvation();
    test_full_queue();
    test_scoreboard();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameters: ADDR, 5, register address width; SIZE, 32, data width; DEPTH, 2, MDU result queue entries; AGE_MAX, 3, max consecutive denials of queue head.
REQ-002 SHALL have ports:
- Clk  in  1  clock; all state updates on posedge.
- Clr  in  1  reset, asynchronous, active-high.
- wb_valid  in  1  pipeline writeback request.
- wb_addr  in  ADDR  writeback destination.
- wb_data  in  SIZE  writeback data.
- wb_stall  out  1  writeback refused this cycle; upstream holds.
- mdu_valid  in  1  long-latency (mul/div) result present.
- mdu_addr  in  ADDR  MDU destination.
- mdu_data  in  SIZE  MDU data.
- mdu_ready  out  1  queue can accept.
- issue_valid  in  1  long-latency op issued.
- issue_addr  in  ADDR  its destination register.
- rd_addr_a  in  ADDR  decode read port A.
- rd_addr_b  in  ADDR  decode read port B.
- stall_a  out  1  rd_addr_a pending.
- stall_b  out  1  rd_addr_b pending.
- Write_Reg  out  1  register file write enable.
- W_Addr  out  ADDR  register file write address.
- W_Data  out  SIZE  register file write data.

Function
REQ-003 SHALL arbitrate the single register file write port between WB and a DEPTH-entry FIFO of MDU results.
REQ-004 SHALL register Write_Reg/W_Addr/W_Data on posedge; grant decided in cycle N is visible after posedge N and consumed by the register file at the following negedge.
REQ-005 SHALL push an MDU result when mdu_valid && mdu_ready; mdu_ready = (count < DEPTH), from registered count; mdu_valid while full is ignored.
REQ-006 SHALL allow push and pop in the same cycle; count unchanged, order preserved.
REQ-007 SHALL implement FSM states NORMAL and FORCE; wb_stall = 1 only in FORCE (Moore).
REQ-008 In NORMAL: wb_valid && wb_addr != 0 SHALL win the port; else a non-empty queue SHALL pop its head to the port; else Write_Reg = 0.
REQ-009 SHALL keep age counter: +1 each NORMAL cycle with queue non-empty and head not granted; cleared on head grant or queue empty.
REQ-010 SHALL go NORMAL -> FORCE when age = AGE_MAX-1 and head denied again; in FORCE, head SHALL be granted, wb_valid ignored, age cleared, next state NORMAL.
REQ-011 SHALL drop any request with address 0 (no write, no port use); a wb_valid with address 0 SHALL not block the queue.
REQ-012 SHALL keep busy bit per register: set on issue_valid && issue_addr != 0; cleared when a queue entry to that address is written; set SHALL win over clear on the same register in the same cycle.
REQ-013 SHALL drive stall_a = busy[rd_addr_a], stall_b = busy[rd_addr_b], combinational from registered busy; register 0 is never busy.
REQ-014 WB grants to a busy register SHALL not change its busy bit.

Reset
REQ-015 Clr = 1 SHALL immediately force: Write_Reg = 0, W_Addr = 0, W_Data = 0, queue empty, count = 0, mdu_ready = 1, busy all 0, age = 0, state NORMAL, wb_stall = 0.
REQ-016 Clr asserted mid-operation SHALL discard queued results and busy bits; no write SHALL issue in the cycle after release unless requested that cycle.

Verification
REQ-017 WB only: wb_valid, addr 5, data 0xAAAA -> after next posedge Write_Reg = 1, W_Addr = 5, W_Data = 0xAAAA; stall_* unaffected.
REQ-018 Collision: same cycle wb (addr 3) and mdu_valid (addr 7, 0x1234), no further WB -> cycle 1 writes r3, cycle 2 writes r7 = 0x1234.
REQ-019 Starvation: queue holds one entry, wb_valid every cycle -> 3 WB grants, then wb_stall = 1 for one cycle while the queue entry is written, then WB resumes.
REQ-020 Full queue: push 2 entries under continuous WB -> mdu_ready = 0; a third mdu_valid is dropped; after one pop mdu_ready = 1.
REQ-021 Scoreboard: issue r9, rd_addr_a = 9 -> stall_a = 1 until MDU result for r9 is written, then 0 next cycle; issue r0 -> stall never set.
REQ-022 Reset mid-run: Clr with 2 queued entries and busy r4 -> all outputs to REQ-015 values without waiting for a clock edge; no late write of queued data after release.
